ppa_mod_accum: RTL and testbench
================================

Name: ppa_mod_accum

Overview:
- Downstream consumer of the 16-bit parallel-prefix adder's (N+1)-bit sum output.
- Reduces each incoming sum modulo 2^N-1, the residue channel modulus.
- Accumulates a vector of reduced sums, with vector end marked by a last flag.
- Emits one residue per vector over a valid/ready handshake to the next RNS datapath stage.
- Two-stage pipeline: fold stage R, then accumulate stage A.

Parameters:
- N, 16, operand width; input sums are N+1 bits, the modulus is 2^N-1.
- CNT_W, 8, width of the element counter reported per vector.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  in_sum/in_last valid.
- in_ready  output  1  block accepts input this cycle.
- in_sum  input  N+1  adder result {carry, sum}.
- in_last  input  1  final element of current vector.
- out_valid  output  1  out_data/out_count valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  N  vector sum mod 2^N-1, range 0..2^N-2.
- out_count  output  CNT_W  number of elements in the vector, saturating.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset state: out_valid=0, out_data=0, out_count=0, accumulator=0, element counter=0, stage-R valid v_r=0. After reset, in_ready=1.
- Reset mid-vector discards any partial accumulation and any pending result.
- fold(x), x at most N+1 bits:
  - y = x[N-1:0] + x[N] (N+1 bits).
  - z = y[N-1:0] + y[N].
  - If z equals all-ones, z = 0, so the all-ones value is always normalised to 0.
  - Combinational, no extra latency.
- Stage R: on an accept edge (in_valid && in_ready):
  - r <= fold(in_sum), last_r <= in_last, v_r <= 1.
  - Otherwise, if stage A consumes R, v_r <= 0.
- Stage A: when v_r=1 and not stalled:
  - acc_next = fold(acc + r); acc + r never exceeds 2^(N+1)-4.
  - cnt_next = cnt+1, saturating at 2^CNT_W-1.
  - If last_r=0: acc <= acc_next, cnt <= cnt_next.
  - If last_r=1: out_data <= acc_next, out_count <= cnt_next, out_valid <= 1, acc <= 0, cnt <= 0.
- stallA = v_r && last_r && out_valid && !out_ready.
  - Non-last elements are never stalled; they accumulate even while a result waits.
- in_ready = !(v_r && stallA), combinational from registered state and out_ready.
- Output handshake:
  - out_valid clears on an edge where out_ready=1, unless stage A writes a new result on that same edge, in which case it stays 1 with the new data.
  - out_data and out_count are held stable while out_valid && !out_ready.
- Latency: the last element accepted on edge E0 gives an out_valid/out_data update on edge E0+1. Full throughput is one element per cycle while out_ready=1.
- Simultaneous events:
  - An accept into R and A consuming R on the same edge: R is overwritten with the new element, v_r stays 1.
  - A new result written on the same edge the old result is taken: no bubble.
- Single-element vectors (in_last on the first element) are legal and give out_count=1.
- Zero-length vectors do not exist.
- There is no FSM beyond per-stage valid flags. The effective states are:
  - EMPTY (v_r=0).
  - BUSY (v_r=1, not stalled).
  - STALL (stallA=1; in_ready=0 until out_ready).

Test Plan:
1. Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0, out_data=0, out_count=0; in_ready=1 on the first cycle after rst drops; nothing accumulated.
2. Single element: in_sum=17'h1_0005, in_last=1, out_ready=1 -> out_valid on the next edge after accept, out_data=6 (65541 mod 65535), out_count=1, then out_valid=0.
3. Normalisation: vector {17'h0_FFFE, 17'h0_0001} -> out_data=0 (not 16'hFFFF), out_count=2. Single element 17'h0_FFFF -> out_data=0. Single element 17'h1_FFFE -> fold gives 65535 -> out_data=0.
4. Streaming: three vectors of 4 elements {100, 200, 300, 65535} back-to-back with in_valid held, out_ready=1 -> in_ready stays 1 throughout; three results, each out_data=600, out_count=4, on consecutive 4-cycle spacing.
5. Backpressure: out_ready=0 while vector A {5} then vector B {7, 9} arrive -> A result (5,1) holds stable. Element 7 is absorbed. Element 9 stalls in R with in_ready=0. Raise out_ready -> A is taken, B result (16,2) appears on the same edge, and in_ready returns to 1.
6. Reset mid-vector: feed {1000, 2000}, no last; pulse rst; feed {3} with last -> out_data=3, out_count=1.

Source files
------------

// File: rtl/ppa_mod_accum.sv
// rtl/ppa_mod_accum.sv - modulo 2^N-1 vector accumulator for parallel-prefix adder sums
// Two-stage pipeline: fold stage R, accumulate stage A, valid/ready on both sides.
module ppa_mod_accum #(
  parameter int N     = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N:0]       in_sum,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic [CNT_W-1:0] out_count
);

  // End-around-carry reduction; the all-ones alias of zero is normalised to 0.
  function automatic logic [N-1:0] fold(input logic [N:0] x);
    logic [N:0]   y;
    logic [N-1:0] z;
    y = {1'b0, x[N-1:0]} + {{N{1'b0}}, x[N]};
    z = y[N-1:0] + {{(N-1){1'b0}}, y[N]};
    if (z == {N{1'b1}}) z = '0;
    return z;
  endfunction

  logic [N-1:0]     r;
  logic             last_r;
  logic             v_r;
  logic [N-1:0]     acc;
  logic [CNT_W-1:0] cnt;

  logic             stall_a;
  logic             consume;
  logic             accept;
  logic [N:0]       acc_sum;
  logic [N-1:0]     acc_next;
  logic [CNT_W-1:0] cnt_next;

  // Only a finishing element can be held back; partial sums keep flowing.
  assign stall_a  = v_r && last_r && out_valid && !out_ready;
  assign in_ready = !(v_r && stall_a);
  assign accept   = in_valid && in_ready;
  assign consume  = v_r && !stall_a;

  assign acc_sum  = {1'b0, acc} + {1'b0, r};
  assign acc_next = fold(acc_sum);
  assign cnt_next = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r         <= '0;
      last_r    <= 1'b0;
      v_r       <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
    end else begin
      if (accept) begin
        r      <= fold(in_sum);
        last_r <= in_last;
        v_r    <= 1'b1;
      end else if (consume) begin
        v_r    <= 1'b0;
      end

      if (consume && !last_r) begin
        acc <= acc_next;
        cnt <= cnt_next;
      end else if (consume && last_r) begin
        out_data  <= acc_next;
        out_count <= cnt_next;
        acc       <= '0;
        cnt       <= '0;
      end

      // A fresh result on the take edge keeps out_valid high with no bubble.
      if (consume && last_r) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ppa_mod_accum.sv
// tb/tb_ppa_mod_accum.sv - directed self-checking bench for ppa_mod_accum
module tb_ppa_mod_accum;

  localparam int N     = 16;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N:0]       in_sum;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_data;
  logic [CNT_W-1:0] out_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int stalls   = 0;
  int res_cyc[3];

  ppa_mod_accum #(.N(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one element and hold it until accepted; counts cycles spent stalled.
  task automatic push(input logic [N:0] s, input logic l);
    int t;
    t        = 0;
    in_valid = 1'b1;
    in_sum   = s;
    in_last  = l;
    while (!in_ready && t < 50) begin
      step();
      t++;
      stalls++;
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int exp_d, input int exp_c);
    int t;
    t = 0;
    while (!out_valid && t < 40) begin
      step();
      t++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, 32'(out_data), 32'(exp_d));
    check({tag, "_count"}, 32'(out_count), 32'(exp_c));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_sum    = 17'h1_2345;
    in_last   = 1'b1;
    out_ready = 1'b1;

    // 1: reset with in_valid high
    step();
    step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    step();
    check("rst_idle_valid", 32'(out_valid), 32'd0);

    // 2: single element, result one edge after accept
    push(17'h1_0005, 1'b1);
    check("single_pre_valid", 32'(out_valid), 32'd0);
    step();
    wait_result("single", 6, 1);
    step();
    check("single_clear", 32'(out_valid), 32'd0);

    // 3: normalisation of the all-ones residue
    push(17'h0_FFFE, 1'b0);
    push(17'h0_0001, 1'b1);
    wait_result("norm_pair", 0, 2);
    step();
    push(17'h0_FFFF, 1'b1);
    wait_result("norm_ffff", 0, 1);
    step();
    push(17'h1_FFFE, 1'b1);
    wait_result("norm_1fffe", 0, 1);
    step();

    // 4: three back-to-back vectors at full throughput
    stalls = 0;
    fork
      begin
        for (int v = 0; v < 3; v++) begin
          push(17'd100, 1'b0);
          push(17'd200, 1'b0);
          push(17'd300, 1'b0);
          push(17'd65535, 1'b1);
        end
      end
      begin
        for (int k = 0; k < 3; k++) begin
          wait_result("stream", 600, 4);
          res_cyc[k] = cyc;
          step();
        end
      end
    join
    check("stream_no_stall", 32'(stalls), 32'd0);
    check("stream_gap1", 32'(res_cyc[1] - res_cyc[0]), 32'd4);
    check("stream_gap2", 32'(res_cyc[2] - res_cyc[1]), 32'd4);

    // 5: backpressure; only the finishing element stalls
    out_ready = 1'b0;
    push(17'd5, 1'b1);
    push(17'd7, 1'b0);
    in_valid = 1'b1;
    in_sum   = 17'd9;
    in_last  = 1'b1;
    check("bp_accept9_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("bp_a_valid", 32'(out_valid), 32'd1);
    check("bp_a_data", 32'(out_data), 32'd5);
    check("bp_a_count", 32'(out_count), 32'd1);
    check("bp_stall_ready", 32'(in_ready), 32'd0);
    step();
    step();
    check("bp_hold_data", 32'(out_data), 32'd5);
    check("bp_hold_count", 32'(out_count), 32'd1);
    check("bp_hold_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step();
    check("bp_b_valid", 32'(out_valid), 32'd1);
    check("bp_b_data", 32'(out_data), 32'd16);
    check("bp_b_count", 32'(out_count), 32'd2);
    check("bp_ready_back", 32'(in_ready), 32'd1);
    step();
    check("bp_b_taken", 32'(out_valid), 32'd0);

    // 6: reset mid-vector drops the partial sum
    push(17'd1000, 1'b0);
    push(17'd2000, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    push(17'd3, 1'b1);
    wait_result("midrst", 3, 1);
    step();

    // counter saturates at 2^CNT_W-1 while the sum keeps going
    for (int i = 0; i < 259; i++) push(17'd1, 1'b0);
    push(17'd1, 1'b1);
    wait_result("sat", 260, 255);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

endmodule
